hex_entry_display: RTL and testbench
====================================

Name: hex_entry_display

Overview:
- Parametrised successor to the fixed 4/8-bit number-entry path: a WIDTH-bit up/down value register driven by held (debounced) keys.
- Keys support auto-repeat, wrap or saturate mode, and parallel load.
- Includes an integrated DIGITS-digit multiplexed seven-segment hex scanner.
- Sits between the key debouncer and the board display pins, and exports the value to downstream converters (float, UART).

Parameters:
- WIDTH, 8, value width in bits; must be a multiple of 4.
- DIGITS, WIDTH/4, number of scanned hex digits; digit 0 is the least-significant nibble.
- REPEAT_DELAY, 50_000_000, cycles a key must stay held before the first auto-repeat step.
- REPEAT_RATE, 5_000_000, cycles between subsequent auto-repeat steps; must be ≥ 1.
- SCAN_DIV, 50_000, cycles each digit stays enabled.

Ports:
- sys_clk  in  1  system clock
- sys_rst  in  1  asynchronous active-low reset
- key_inc  in  1  debounced level, 1 = increment key held
- key_dec  in  1  debounced level, 1 = decrement key held
- wrap_en  in  1  1 = modular wrap at limits; 0 = saturate
- load  in  1  single-cycle strobe, load load_val
- load_val  in  WIDTH  value to load
- value  out  WIDTH  current value
- limit  out  1  one-cycle pulse on wrap or on a saturated (blocked) step
- com  out  DIGITS  digit enables, active-low, one-hot-zero
- seg  out  8  segments active-low; seg[7] = decimal point, seg[6:0] = gfedcba

Behaviour:
- Reset (sys_rst=0, asynchronous): value=0, limit=0, com=all ones except bit0=0, seg=digit0 pattern for 0 (8'b1100_0000), all timers/flags=0.
- Key sampling:
  - Each key is registered every cycle into k_q.
  - A step event occurs on the rising clock edge at which the key is sampled 1 and k_q=0 (press); value shows the new value after that edge (1-cycle latency from sampled key).
- Hold timer:
  - The timer counts while exactly one key is held.
  - At count REPEAT_DELAY-1 after the press edge, one step occurs and the timer reloads.
  - After that, a step occurs every REPEAT_RATE cycles until release.
  - Release clears the timer.
- Priority per cycle: load > (key_inc and key_dec both 1: no step, timer cleared, held-state cleared) > single-key step.
  - load sets value=load_val and clears repeat timers.
  - A key still held after a load does not step until it is released and pressed again.
- Increment at max (all ones):
  - wrap_en=1: value=0, limit=1 for 1 cycle.
  - wrap_en=0: value unchanged, limit=1.
- Decrement at 0:
  - wrap_en=1: value=all ones, limit=1.
  - wrap_en=0: value unchanged, limit=1.
- limit is 0 in all other cycles, including on load.
- Arithmetic: unsigned, modulo 2^WIDTH; no other flags.
- Scanner:
  - A free-running divider counts 0..SCAN_DIV-1.
  - On terminal count, the digit index advances (DIGITS-1 wraps to 0).
  - com and seg are registered together, so they never show a mixed digit.
  - Digit i displays value[4i+3:4i], sampled at the advance edge.
- Hex font (seg[6:0], active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- seg[7]=1 always.
- Reset mid-hold or mid-scan: everything returns to reset values immediately. A key held through reset release does not step until it is released and pressed again (k_q resets to 1 is NOT used; instead a post-reset held-key is masked until first 0 sample).

Test Plan:
- Reset release with keys low; 3 key_inc presses (each 1 cycle high, 2 low) → value=0x03, limit never 1.
- load=1 with load_val=0xFF, wrap_en=1, then one key_inc press → value=0x00, limit pulses once. Repeat with wrap_en=0 → value stays 0xFF, limit pulses.
- REPEAT_DELAY=10, REPEAT_RATE=3, key_dec held 20 cycles from value 0x10 → steps at press, +10 cycles, +13, +16, +19 → value=0x0B. Release, hold 2 cycles → exactly one more step.
- key_inc and key_dec both held 30 cycles → value unchanged. Drop key_dec while key_inc stays held → no step until key_inc is re-pressed.
- WIDTH=8, SCAN_DIV=4, value=0x3A → com alternates 2'b10 (seg=0001000, "A") and 2'b01 (seg=0110000, "3"), each held 4 cycles.
- Assert sys_rst during a repeat hold with value=0x55 → value=0, com=2'b10, seg=8'hC0 asynchronously. Key still held after release → no step.

Source files
------------

// File: rtl/hex_entry_display.sv
// hex_entry_display: key-driven up/down value register with auto-repeat,
// wrap/saturate limits, parallel load and a multiplexed hex display scanner.
module hex_entry_display #(
   parameter int WIDTH        = 8,
   parameter int DIGITS       = WIDTH / 4,
   parameter int REPEAT_DELAY = 50_000_000,
   parameter int REPEAT_RATE  = 5_000_000,
   parameter int SCAN_DIV     = 50_000
) (
   input  logic              sys_clk,
   input  logic              sys_rst,
   input  logic              key_inc,
   input  logic              key_dec,
   input  logic              wrap_en,
   input  logic              load,
   input  logic [WIDTH-1:0]  load_val,
   output logic [WIDTH-1:0]  value,
   output logic              limit,
   output logic [DIGITS-1:0] com,
   output logic [7:0]        seg
);

   localparam int TMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int TW   = $clog2(TMAX + 1);
   localparam int SW   = $clog2(SCAN_DIV + 1);
   localparam int IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   localparam logic [TW-1:0]    DELAY_LD  = TW'(REPEAT_DELAY - 1);
   localparam logic [TW-1:0]    RATE_LD   = TW'(REPEAT_RATE - 1);
   localparam logic [SW-1:0]    SCAN_LAST = SW'(SCAN_DIV - 1);
   localparam logic [IW-1:0]    IDX_LAST  = IW'(DIGITS - 1);
   localparam logic [WIDTH-1:0] VAL_MAX   = '1;

   function automatic logic [6:0] hex_font(input logic [3:0] n);
      case (n)
         4'h0: hex_font = 7'b1000000;
         4'h1: hex_font = 7'b1111001;
         4'h2: hex_font = 7'b0100100;
         4'h3: hex_font = 7'b0110000;
         4'h4: hex_font = 7'b0011001;
         4'h5: hex_font = 7'b0010010;
         4'h6: hex_font = 7'b0000010;
         4'h7: hex_font = 7'b1111000;
         4'h8: hex_font = 7'b0000000;
         4'h9: hex_font = 7'b0010000;
         4'hA: hex_font = 7'b0001000;
         4'hB: hex_font = 7'b0000011;
         4'hC: hex_font = 7'b1000110;
         4'hD: hex_font = 7'b0100001;
         4'hE: hex_font = 7'b0000110;
         default: hex_font = 7'b0001110;
      endcase
   endfunction

   // k_q: previous key samples. *_arm: key has been seen released since the
   // last reset, load or both-keys event; an unarmed key can never step.
   logic          inc_q, dec_q;
   logic          inc_arm, dec_arm;
   logic          inc_arm_nxt, dec_arm_nxt;
   logic [TW-1:0] hold_cnt, hold_cnt_nxt;
   logic          do_inc, do_dec;

   // Step decision, hold-timer next value and arming for this cycle.
   always_comb begin
      do_inc       = 1'b0;
      do_dec       = 1'b0;
      hold_cnt_nxt = '0;
      inc_arm_nxt  = inc_arm | ~key_inc;
      dec_arm_nxt  = dec_arm | ~key_dec;
      if (load) begin
         inc_arm_nxt = ~key_inc;
         dec_arm_nxt = ~key_dec;
      end else if (key_inc && key_dec) begin
         inc_arm_nxt = 1'b0;
         dec_arm_nxt = 1'b0;
      end else if (key_inc && inc_arm) begin
         if (!inc_q) begin
            do_inc       = 1'b1;
            hold_cnt_nxt = DELAY_LD;
         end else if (hold_cnt == '0) begin
            do_inc       = 1'b1;
            hold_cnt_nxt = RATE_LD;
         end else begin
            hold_cnt_nxt = hold_cnt - TW'(1);
         end
      end else if (key_dec && dec_arm) begin
         if (!dec_q) begin
            do_dec       = 1'b1;
            hold_cnt_nxt = DELAY_LD;
         end else if (hold_cnt == '0) begin
            do_dec       = 1'b1;
            hold_cnt_nxt = RATE_LD;
         end else begin
            hold_cnt_nxt = hold_cnt - TW'(1);
         end
      end
   end

   // Key history, arming flags and the repeat down-counter.
   always_ff @(posedge sys_clk or negedge sys_rst) begin
      if (!sys_rst) begin
         inc_q    <= 1'b0;
         dec_q    <= 1'b0;
         inc_arm  <= 1'b0;
         dec_arm  <= 1'b0;
         hold_cnt <= '0;
      end else begin
         inc_q    <= key_inc;
         dec_q    <= key_dec;
         inc_arm  <= inc_arm_nxt;
         dec_arm  <= dec_arm_nxt;
         hold_cnt <= hold_cnt_nxt;
      end
   end

   // Value register with wrap/saturate at the limits; limit pulses on those steps.
   always_ff @(posedge sys_clk or negedge sys_rst) begin
      if (!sys_rst) begin
         value <= '0;
         limit <= 1'b0;
      end else begin
         limit <= 1'b0;
         if (load) begin
            value <= load_val;
         end else if (do_inc) begin
            if (value == VAL_MAX) begin
               limit <= 1'b1;
               if (wrap_en) value <= '0;
            end else begin
               value <= value + WIDTH'(1);
            end
         end else if (do_dec) begin
            if (value == '0) begin
               limit <= 1'b1;
               if (wrap_en) value <= VAL_MAX;
            end else begin
               value <= value - WIDTH'(1);
            end
         end
      end
   end

   logic [SW-1:0] scan_cnt;
   logic [IW-1:0] idx, idx_nxt;
   logic [3:0]    nib_nxt;

   // Next digit index and the nibble it will show.
   always_comb begin
      idx_nxt = (idx == IDX_LAST) ? '0 : idx + IW'(1);
      nib_nxt = 4'(value >> {idx_nxt, 2'b00});
   end

   // Scan divider; com and seg update together so a digit is never mixed.
   always_ff @(posedge sys_clk or negedge sys_rst) begin
      if (!sys_rst) begin
         scan_cnt <= '0;
         idx      <= '0;
         com      <= ~DIGITS'(1);
         seg      <= 8'b1100_0000;
      end else if (scan_cnt == SCAN_LAST) begin
         scan_cnt <= '0;
         idx      <= idx_nxt;
         com      <= ~(DIGITS'(1) << idx_nxt);
         seg      <= {1'b1, hex_font(nib_nxt)};
      end else begin
         scan_cnt <= scan_cnt + SW'(1);
      end
   end

endmodule

// File: tb/tb_hex_entry_display.sv
// Scoreboarded directed bench for hex_entry_display (WIDTH=8, short timers).
module tb_hex_entry_display;

   logic       clk = 1'b0;
   logic       sys_rst;
   logic       key_inc, key_dec, wrap_en, load;
   logic [7:0] load_val;
   logic [7:0] value;
   logic       limit;
   logic [1:0] com;
   logic [7:0] seg;

   int checks   = 0;
   int failures = 0;
   int lim_total = 0;

   string       tag_q[$];
   logic [31:0] exp_q[$];

   always #5 clk = ~clk;

   hex_entry_display #(
      .WIDTH(8), .DIGITS(2), .REPEAT_DELAY(10), .REPEAT_RATE(3), .SCAN_DIV(4)
   ) dut (
      .sys_clk(clk), .sys_rst(sys_rst), .key_inc(key_inc), .key_dec(key_dec),
      .wrap_en(wrap_en), .load(load), .load_val(load_val), .value(value),
      .limit(limit), .com(com), .seg(seg)
   );

   // Count limit pulses as seen at the sampling edge.
   always @(negedge clk) if (limit === 1'b1) lim_total++;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push(input string tag, input logic [31:0] v);
      tag_q.push_back(tag);
      exp_q.push_back(v);
   endtask

   task automatic pop(input logic [31:0] obs);
      if (exp_q.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
      else chk(tag_q.pop_front(), obs, exp_q.pop_front());
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   int lim_base;
   int d0, d;
   logic [1:0] prev_com;
   bit found;

   initial begin
      sys_rst = 1'b0; key_inc = 1'b0; key_dec = 1'b0;
      wrap_en = 1'b1; load = 1'b0; load_val = 8'h00;
      tick(2);
      push("rst_value", 0);    pop(value);
      push("rst_limit", 0);    pop(limit);
      push("rst_com", 2'b10);  pop(com);
      push("rst_seg", 8'hC0);  pop(seg);
      sys_rst = 1'b1;
      tick(1);

      // three single-cycle presses
      lim_base = lim_total;
      for (int i = 1; i <= 3; i++) begin
         key_inc = 1'b1;
         push("press_inc", i);
         tick(1);
         pop(value);
         key_inc = 1'b0;
         tick(2);
      end
      push("press_no_limit", 0); pop(lim_total - lim_base);

      // wrap at max
      load = 1'b1; load_val = 8'hFF; wrap_en = 1'b1;
      push("load_ff", 8'hFF); push("load_limit", 0);
      tick(1); load = 1'b0;
      pop(value); pop(limit);
      lim_base = lim_total;
      key_inc = 1'b1;
      push("wrap_inc_val", 8'h00); push("wrap_inc_lim", 1);
      tick(1); pop(value); pop(limit);
      key_inc = 1'b0; tick(2);
      push("wrap_inc_pulses", 1); pop(lim_total - lim_base);

      // saturate at max
      load = 1'b1; load_val = 8'hFF; wrap_en = 1'b0;
      tick(1); load = 1'b0;
      lim_base = lim_total;
      key_inc = 1'b1;
      push("sat_inc_val", 8'hFF); push("sat_inc_lim", 1);
      tick(1); pop(value); pop(limit);
      key_inc = 1'b0; tick(2);
      push("sat_inc_pulses", 1); pop(lim_total - lim_base);

      // wrap at zero on decrement
      load = 1'b1; load_val = 8'h00; wrap_en = 1'b1;
      tick(1); load = 1'b0;
      key_dec = 1'b1;
      push("wrap_dec_val", 8'hFF); push("wrap_dec_lim", 1);
      tick(1); pop(value); pop(limit);
      key_dec = 1'b0; tick(2);

      // auto-repeat: steps at press, +10, +13, +16, +19
      load = 1'b1; load_val = 8'h10;
      tick(1); load = 1'b0;
      key_dec = 1'b1;
      push("rep_first", 8'h0F); tick(1);  pop(value);
      push("rep_wait", 8'h0F);  tick(9);  pop(value);
      push("rep_delay", 8'h0E); tick(1);  pop(value);
      push("rep_end", 8'h0B);   tick(9);  pop(value);
      key_dec = 1'b0; tick(1);
      key_dec = 1'b1;
      push("rep_short", 8'h0A); tick(2);
      key_dec = 1'b0; tick(1); pop(value);

      // both keys: no step; survivor does not step until re-pressed
      lim_base = lim_total;
      key_inc = 1'b1; key_dec = 1'b1;
      push("both_held", 8'h0A); tick(30); pop(value);
      key_dec = 1'b0;
      push("survivor", 8'h0A);  tick(15); pop(value);
      key_inc = 1'b0; tick(1);
      key_inc = 1'b1;
      push("repress", 8'h0B);   tick(1);  pop(value);
      key_inc = 1'b0; tick(1);
      push("both_no_limit", 0); pop(lim_total - lim_base);

      // scanner: 0x3A shows "A" on digit 0, "3" on digit 1, 4 cycles each
      load = 1'b1; load_val = 8'h3A;
      tick(1); load = 1'b0;
      tick(10);
      prev_com = com; found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         tick(1);
         if (com !== prev_com) found = 1'b1;
         else prev_com = com;
      end
      if (!found) chk("scan_sync_timeout", 32'd0, 32'd1);
      d0 = (com == 2'b01) ? 1 : 0;
      for (int j = 0; j < 16; j++) begin
         d = (d0 + j / 4) % 2;
         push("scan_com", (d == 0) ? 2'b10 : 2'b01);
         push("scan_seg", (d == 0) ? 8'h88 : 8'hB0);
         pop(com); pop(seg);
         tick(1);
      end

      // asynchronous reset during a hold
      load = 1'b1; load_val = 8'h55;
      tick(1); load = 1'b0;
      key_inc = 1'b1;
      push("pre_rst", 8'h56); tick(5); pop(value);
      #2 sys_rst = 1'b0;
      #1;
      push("async_value", 0);   pop(value);
      push("async_com", 2'b10); pop(com);
      push("async_seg", 8'hC0); pop(seg);
      push("async_limit", 0);   pop(limit);
      tick(2);
      sys_rst = 1'b1;
      push("held_thru_rst", 0); tick(15); pop(value);
      key_inc = 1'b0; tick(1);
      key_inc = 1'b1;
      push("after_rst_press", 1); tick(1); pop(value);
      key_inc = 1'b0; tick(1);

      chk("sb_drain", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
